sort_loader: RTL

Upstream stage for `bitonic_sort`. Accepts a serial, `BITS`-wide element stream with valid/ready and packs `WIDTH` elements per word. Writes each packed word into the SRAM write port starting at a base address. Once the stream ends, it issues a single sort request to the sorter and hands the SRAM write port to the sorter until sorting completes.

---
 rtl/sort_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sort_loader.sv
// sort_loader: packs a serial element stream into SRAM words, then hands the write port to bitonic_sort.
// Optional macro SORT_LOADER_PAD_EN: pad a partial final word with all-ones instead of dropping it.
module sort_loader #(
  parameter int WIDTH  = 4,
  parameter int BITS   = 8,
  parameter int ADDR   = 10,
  parameter int MAXCNT = 1024
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic [BITS-1:0]            in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic [ADDR-1:0]            load_addr,
  output logic                       wr_en,
  output logic [ADDR-1:0]            wr_addr,
  output logic [WIDTH-1:0][BITS-1:0] wr_data,
  input  logic                       sort_active,
  output logic                       sort_req,
  output logic [ADDR-1:0]            start_addr,
  output logic [ADDR:0]              data_count,
  output logic                       write_sel,
  output logic                       load_done,
  output logic                       load_err
);

  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR:0] MAXC = (ADDR+1)'(MAXCNT);
  localparam logic [ADDR:0] ONE  = (ADDR+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_REQ, S_SORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                       r_armed;
  logic [LW-1:0]              r_lane;
  logic [ADDR:0]              r_cnt;
  logic [ADDR-1:0]            r_base;
  logic [WIDTH-1:0][BITS-1:0] r_word;
  logic                       r_wr_en;
  logic [ADDR-1:0]            r_wr_addr;
  logic [WIDTH-1:0][BITS-1:0] r_wr_data;
  logic                       r_done;
  logic                       r_err;

  logic                       w_first;
  logic                       w_acc;
  logic [LW-1:0]              w_lane;
  logic [ADDR:0]              w_cnt;
  logic [ADDR:0]              w_cnt_inc;
  logic [ADDR-1:0]            w_base;
  logic [WIDTH-1:0][BITS-1:0] w_word;
  logic [WIDTH-1:0][BITS-1:0] w_wdata;
  logic                       w_full;
  logic                       w_ovf;
  logic                       w_wr;
  logic                       w_err;

  // The first beat of a load restarts lane, count and base.
  assign w_first   = (r_state == S_IDLE);
  assign w_acc     = in_valid & in_ready;
  assign w_lane    = w_first ? '0 : r_lane;
  assign w_cnt     = w_first ? '0 : r_cnt;
  assign w_base    = w_first ? load_addr : r_base;
  assign w_cnt_inc = w_cnt + ONE;
  assign w_full    = (w_lane == LW'(WIDTH-1));
  assign w_ovf     = w_full & ~in_last & (w_cnt_inc == MAXC);

  always_comb begin
    w_word = r_word;
    w_word[w_lane] = in_data;
  end

`ifdef SORT_LOADER_PAD_EN
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_wdata[i] = (LW'(i) > w_lane) ? {BITS{1'b1}} : w_word[i];
    end
  end
  assign w_wr  = w_acc & (w_full | in_last);
  assign w_err = w_acc & w_ovf;
`else
  assign w_wdata = w_word;
  assign w_wr    = w_acc & w_full;
  assign w_err   = w_acc & (w_ovf | (in_last & ~w_full));
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_acc) begin
          w_next = (in_last | w_ovf) ? S_FLUSH : S_LOAD;
        end
      end
      S_FLUSH: begin
        if (!r_wr_en) begin
          w_next = (r_cnt == '0) ? S_IDLE : S_REQ;
        end
      end
      S_REQ: begin
        if (sort_active) begin
          w_next = S_SORT;
        end
      end
      S_SORT: begin
        if (!sort_active) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_armed & ((r_state == S_IDLE) | (r_state == S_LOAD));
    sort_req  = (r_state == S_REQ);
    write_sel = (r_state == S_REQ) | (r_state == S_SORT);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_armed   <= 1'b0;
      r_lane    <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_word    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_wr_en <= w_wr;
      r_err   <= w_err;
      r_done  <= (r_state == S_SORT) & ~sort_active;
      if (w_acc) begin
        r_word <= w_word;
        r_lane <= w_full ? '0 : w_lane + LW'(1);
        r_base <= w_base;
        r_cnt  <= w_wr ? w_cnt_inc : w_cnt;
      end
      if (w_wr) begin
        r_wr_addr <= w_base + w_cnt[ADDR-1:0];
        r_wr_data <= w_wdata;
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign start_addr = r_base;
  assign data_count = r_cnt;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule
